// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM state encoding and the fixed
// byte-enable width of the memory connection.
package sram_arbiter_pkg;

  localparam int BE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DUMP  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester set in req_i, scanning
// upward from last_grant_i+1 with wrap-around.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic             found_o,
  output logic [IDX_W-1:0] winner_o
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand_s;
  logic          hit_s;

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    cand_s   = '0;
    hit_s    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // last_grant + i + 1 never exceeds 2*N_REQ-1, so one subtraction wraps it.
      cand_s   = {1'b0, last_grant_i} + CW'(i + 1);
      cand_s   = (cand_s >= CW'(N_REQ)) ? (cand_s - CW'(N_REQ)) : cand_s;
      hit_s    = !found_o && req_i[cand_s[IDX_W-1:0]];
      winner_o = hit_s ? cand_s[IDX_W-1:0] : winner_o;
      found_o  = found_o | hit_s;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port SRAM between N_REQ
// requesters, with a drain-then-dump sequence for the memory image.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int ADDR_W = 12,
  parameter  int DATA_W = 8,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [BE_W*N_REQ-1:0]    byte_en,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  input  logic                     dump_req,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [BE_W-1:0]          mem_byte_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     mem_dump
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   mem_byte_en_q, mem_byte_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_dump_q, mem_dump_d;
  logic              busy_q, busy_d;
  logic              dump_armed_q, dump_armed_d;

  logic              found_s;
  logic [IDX_W-1:0]  winner_s;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .found_o      (found_s),
    .winner_o     (winner_s)
  );

  // Next-state and registered-output logic; outputs are computed one cycle
  // ahead so every port comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    we_d          = we_q;
    mem_byte_en_d = mem_byte_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    ack_d         = '0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_dump_d    = 1'b0;
    // The dump flag re-arms whenever dump_req is seen low, in any state.
    dump_armed_d  = dump_req ? dump_armed_q : 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (dump_req && dump_armed_q) begin
          state_d      = ST_DUMP;
          mem_dump_d   = 1'b1;
          dump_armed_d = 1'b0;
        end else if (found_s) begin
          state_d       = ST_ISSUE;
          grant_id_d    = winner_s;
          last_grant_d  = winner_s;
          we_d          = we[winner_s];
          mem_byte_en_d = byte_en[int'(winner_s)*BE_W +: BE_W];
          mem_addr_d    = addr[int'(winner_s)*ADDR_W +: ADDR_W];
          mem_wdata_d   = wdata[int'(winner_s)*DATA_W +: DATA_W];
          mem_write_d   = we[winner_s];
          mem_read_d    = !we[winner_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d           = ST_DONE;
          ack_d[grant_id_q] = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d           = ST_DONE;
        rdata_d           = mem_rdata;
        ack_d[grant_id_q] = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DUMP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= IDX_W'(N_REQ - 1);
      grant_id_q    <= '0;
      we_q          <= 1'b0;
      mem_byte_en_q <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      ack_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_dump_q    <= 1'b0;
      busy_q        <= 1'b0;
      dump_armed_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      we_q          <= we_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      ack_q         <= ack_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_dump_q    <= mem_dump_d;
      busy_q        <= busy_d;
      dump_armed_q  <= dump_armed_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_dump    = mem_dump_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_sram_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 2;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [2*N_REQ-1:0]      byte_en;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic [IDX_W-1:0]        grant_id;
  logic                    busy;
  logic                    dump_req;
  logic                    mem_read;
  logic                    mem_write;
  logic [1:0]              mem_byte_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    mem_dump;

  sram_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .byte_en     (byte_en),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .grant_id    (grant_id),
    .busy        (busy),
    .dump_req    (dump_req),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_byte_en (mem_byte_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_dump    (mem_dump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // One expected cycle of the port: strobes, ack, busy.
  typedef struct packed {
    logic rd;
    logic wr;
    logic dmp;
    logic ak;
    logic bsy;
  } slot_t;

  slot_t             plan_q[$];
  slot_t             cur;
  int                m_last;
  logic [IDX_W-1:0]  m_gid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic [DATA_W-1:0] m_rd_exp;
  logic [1:0]        m_be;
  logic              m_is_read;
  logic              m_armed;
  logic [DATA_W-1:0] ref_mem [0:4095];
  logic [DATA_W-1:0] tb_mem  [0:4095];

  // Bench-side memory strobes sampled mid-cycle, applied after the next edge.
  logic              s_rd, s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;

  int mode;        // 0: drop req at ack, 1: hold req (same op), 2: random
  logic rec_on;
  int grants_q[$];
  int dump_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t mk(input logic rd, input logic wr, input logic dmp, input logic ak, input logic bsy);
    slot_t s;
    s = {rd, wr, dmp, ak, bsy};
    return s;
  endfunction

  task automatic model_reset();
    plan_q.delete();
    cur       = '0;
    m_last    = N_REQ - 1;
    m_gid     = '0;
    m_addr    = '0;
    m_wdata   = '0;
    m_rdata   = '0;
    m_be      = '0;
    m_is_read = 1'b0;
    m_armed   = 1'b1;
  endtask

  // Reference model, stepped at each active edge with the inputs the DUT sees.
  task automatic model_step();
    logic dump_now;
    int   w;
    dump_now = dump_req && m_armed;
    if (!dump_req) m_armed = 1'b1;
    if (plan_q.size() == 0) begin
      if (dump_now) begin
        m_armed = 1'b0;
        plan_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        plan_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end else if (req != '0) begin
        w = -1;
        for (int k = 1; k <= N_REQ; k++) begin
          if (w < 0 && req[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
        end
        m_last    = w;
        m_gid     = IDX_W'(w);
        m_addr    = addr[w*ADDR_W +: ADDR_W];
        m_wdata   = wdata[w*DATA_W +: DATA_W];
        m_be      = byte_en[w*2 +: 2];
        m_is_read = !we[w];
        if (we[w]) begin
          plan_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
          plan_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
          plan_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end else begin
          m_rd_exp = ref_mem[m_addr];
          plan_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
          plan_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
          plan_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
          plan_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
      end else begin
        plan_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
    cur = plan_q.pop_front();
    if (cur.ak) begin
      if (m_is_read) m_rdata = m_rd_exp;
      else           ref_mem[m_addr] = m_wdata;
    end
  endtask

  task automatic compare();
    logic [N_REQ-1:0] exp_ack;
    exp_ack = cur.ak ? (N_REQ'(1) << m_gid) : '0;
    check_eq("ack",         32'(ack),         32'(exp_ack));
    check_eq("mem_read",    32'(mem_read),    32'(cur.rd));
    check_eq("mem_write",   32'(mem_write),   32'(cur.wr));
    check_eq("mem_dump",    32'(mem_dump),    32'(cur.dmp));
    check_eq("busy",        32'(busy),        32'(cur.bsy));
    check_eq("grant_id",    32'(grant_id),    32'(m_gid));
    check_eq("mem_addr",    32'(mem_addr),    32'(m_addr));
    check_eq("mem_wdata",   32'(mem_wdata),   32'(m_wdata));
    check_eq("mem_byte_en", 32'(mem_byte_en), 32'(m_be));
    check_eq("rdata",       32'(rdata),       32'(m_rdata));
  endtask

  task automatic set_op(input int i, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [1:0] be);
    we[i]                    = w;
    addr[i*ADDR_W +: ADDR_W] = a;
    wdata[i*DATA_W +: DATA_W] = d;
    byte_en[i*2 +: 2]        = be;
    req[i]                   = 1'b1;
  endtask

  task automatic rand_op(input int i);
    set_op(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
           DATA_W'($urandom), 2'($urandom_range(0, 3)));
  endtask

  // Requester behaviour for the coming cycle, reacting to the expected ack.
  task automatic drive_next();
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && cur.ak && int'(m_gid) == i) begin
        if (mode == 1) req[i] = 1'b1;
        else if (mode == 2 && $urandom_range(0, 1) == 1) rand_op(i);
        else req[i] = 1'b0;
      end else if (!req[i]) begin
        if (mode == 2 && $urandom_range(0, 3) == 0) rand_op(i);
      end else if (mode == 2 && int'(m_gid) == i && plan_q.size() >= 2) begin
        rand_op(i);   // operands of a granted requester must be ignored
      end
    end
    if (mode == 2 && $urandom_range(0, 31) == 0) dump_req = ~dump_req;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (s_wr) tb_mem[s_addr] = s_wdata;
    if (s_rd) mem_rdata = tb_mem[s_addr];
    @(negedge clk);
    compare();
    if (rec_on && (cur.rd || cur.wr)) grants_q.push_back(int'(grant_id));
    if (mem_dump) dump_seen++;
    s_rd    = mem_read;
    s_wr    = mem_write;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    drive_next();
  endtask

  // Called at a negedge: asserts reset, checks the reset state, releases it.
  task automatic apply_reset();
    rst      = 1'b0;
    req      = '0;
    dump_req = 1'b0;
    s_rd     = 1'b0;
    s_wr     = 1'b0;
    #1;
    model_reset();
    compare();
    #2;
    rst = 1'b1;
  endtask

  task automatic check_order(input string tag, input int exp_ids[5], input int n);
    check_eq({tag, "_count_ok"}, 32'(grants_q.size() >= n), 32'(1));
    for (int k = 0; k < n && k < grants_q.size(); k++) begin
      check_eq($sformatf("%s_grant%0d", tag, k), 32'(grants_q[k]), 32'(exp_ids[k]));
    end
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    we        = '0;
    byte_en   = '0;
    addr      = '0;
    wdata     = '0;
    dump_req  = 1'b0;
    mem_rdata = '0;
    mode      = 0;
    rec_on    = 1'b0;
    dump_seen = 0;
    for (int a = 0; a < 4096; a++) begin
      ref_mem[a] = DATA_W'(a * 37 + 11);
      tb_mem[a]  = DATA_W'(a * 37 + 11);
    end
    model_reset();
    @(negedge clk);
    apply_reset();

    // Write then read back the same word.
    set_op(0, 1'b1, 12'h005, 8'hA5, 2'b11);
    cycle();
    check_eq("t1_mem_write", 32'(mem_write), 32'(1));
    check_eq("t1_mem_addr",  32'(mem_addr),  32'h005);
    check_eq("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
    cycle();
    check_eq("t1_ack", 32'(ack), 32'(4'b0001));
    cycle();
    set_op(0, 1'b0, 12'h005, 8'h00, 2'b11);
    cycle();
    check_eq("t2_mem_read", 32'(mem_read), 32'(1));
    cycle();
    cycle();
    check_eq("t2_ack",   32'(ack),   32'(4'b0001));
    check_eq("t2_rdata", 32'(rdata), 32'hA5);
    cycle();

    // All four requesters reading continuously after reset.
    apply_reset();
    mode = 1;
    for (int i = 0; i < N_REQ; i++) set_op(i, 1'b0, ADDR_W'(i + 1), 8'h00, 2'b01);
    grants_q.delete();
    rec_on = 1'b1;
    repeat (22) cycle();
    check_order("t3", '{0, 1, 2, 3, 0}, 5);

    // r1 rises while r3 is being served; r3 keeps requesting.
    apply_reset();
    mode = 1;
    set_op(3, 1'b1, 12'h009, 8'h33, 2'b10);
    grants_q.delete();
    cycle();
    set_op(1, 1'b1, 12'h00A, 8'h11, 2'b00);
    repeat (10) cycle();
    check_order("t4", '{3, 1, 3, 0, 0}, 3);

    // dump_req rises during a read's WAIT and is held.
    rec_on = 1'b0;
    apply_reset();
    mode = 0;
    set_op(1, 1'b0, 12'h005, 8'h00, 2'b11);
    cycle();
    cycle();
    dump_req  = 1'b1;
    dump_seen = 0;
    set_op(0, 1'b1, 12'h00C, 8'h5A, 2'b11);
    repeat (14) cycle();
    check_eq("t5_dump_pulses", 32'(dump_seen), 32'(1));
    dump_req = 1'b0;
    cycle();

    // Reset during ISSUE of a write, then r0 and r2 compete.
    apply_reset();
    set_op(0, 1'b1, 12'h00B, 8'h3C, 2'b11);
    cycle();
    check_eq("t6_issue_write", 32'(mem_write), 32'(1));
    apply_reset();
    set_op(0, 1'b0, 12'h00B, 8'h00, 2'b11);
    set_op(2, 1'b0, 12'h003, 8'h00, 2'b11);
    grants_q.delete();
    rec_on = 1'b1;
    repeat (10) cycle();
    check_order("t6", '{0, 2, 0, 0, 0}, 2);
    rec_on = 1'b0;

    // Randomized traffic with random dump requests.
    apply_reset();
    mode = 2;
    repeat (3000) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
